// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of the two requester ports, the shared memory port
//                and the busy/stall flag served by mem_port_arbiter.
//                slave  = the arbiter side, master = requesters + memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if;
  // requester 0 (fetch)
  logic        r0_req;
  logic [3:0]  r0_we;
  logic [31:0] r0_addr;
  logic [31:0] r0_wdata;
  logic        r0_gnt;
  logic        r0_done;
  logic        r0_err;
  logic [31:0] r0_rdata;
  // requester 1 (data)
  logic        r1_req;
  logic [3:0]  r1_we;
  logic [31:0] r1_addr;
  logic [31:0] r1_wdata;
  logic        r1_gnt;
  logic        r1_done;
  logic        r1_err;
  logic [31:0] r1_rdata;
  // shared memory port
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_accept_read;
  logic        mem_accept_write;
  // stall source
  logic        busy;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_dout, mem_accept_read, mem_accept_write,
    output r0_gnt, r0_done, r0_err, r0_rdata,
    output r1_gnt, r1_done, r1_err, r1_rdata,
    output mem_en, mem_we, mem_addr, mem_din,
    output busy
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_dout, mem_accept_read, mem_accept_write,
    input  r0_gnt, r0_done, r0_err, r0_rdata,
    input  r1_gnt, r1_done, r1_err, r1_rdata,
    input  mem_en, mem_we, mem_addr, mem_din,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Two-requester round-robin arbiter for a single memory port
//                with per-access accept timeout and one-cycle done pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

  state_t      r_state;
  logic        r_last;      // requester served most recently (1 = r1)
  logic [7:0]  r_cnt;       // unaccepted BUSY cycles so far
  logic [3:0]  r_we;
  logic [31:0] r_addr;
  logic [31:0] r_din;
  logic        r_gnt0;
  logic        r_gnt1;
  logic        r_done0;
  logic        r_done1;
  logic        r_err0;
  logic        r_err1;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic        w_read;
  logic        w_accept;
  logic [7:0]  w_cnt_inc;
  logic        w_timeout;
  logic        w_req0;
  logic        w_req1;
  logic        w_pick1;

  // A requester still sees its own done in the cycle after completion, so
  // its request is masked there to avoid granting the finished access again.
  assign w_req0    = bus.r0_req & ~r_done0;
  assign w_req1    = bus.r1_req & ~r_done1;
  // r1 wins when it is alone, or on a tie when r0 was served last.
  assign w_pick1   = w_req1 & (~w_req0 | ~r_last);

  // Only the accept strobe matching the latched direction counts.
  assign w_read    = (r_we == 4'd0);
  assign w_accept  = w_read ? bus.mem_accept_read : bus.mem_accept_write;
  // Abort at the end of the MAX_WAIT-th unaccepted cycle, i.e. when the wait
  // count would reach MAX_WAIT; an accept in that same cycle still wins.
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_timeout = (w_cnt_inc == c_max_wait);

  // Arbitration FSM with registered grant, done, error and read-data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_cnt    <= 8'd0;
      r_we     <= 4'd0;
      r_addr   <= 32'd0;
      r_din    <= 32'd0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= 32'd0;
      r_rdata1 <= 32'd0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req0 | w_req1) begin
            r_cnt <= 8'd0;
            if (w_pick1) begin
              r_state <= BUSY1;
              r_gnt1  <= 1'b1;
              r_last  <= 1'b1;
              r_we    <= bus.r1_we;
              r_addr  <= bus.r1_addr;
              r_din   <= bus.r1_wdata;
            end else begin
              r_state <= BUSY0;
              r_gnt0  <= 1'b1;
              r_last  <= 1'b0;
              r_we    <= bus.r0_we;
              r_addr  <= bus.r0_addr;
              r_din   <= bus.r0_wdata;
            end
          end
        end
        BUSY0, BUSY1: begin
          if (w_accept || w_timeout) begin
            r_state <= IDLE;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_cnt   <= 8'd0;
            if (r_state == BUSY0) begin
              r_done0  <= 1'b1;
              r_err0   <= ~w_accept;
              r_rdata0 <= (w_accept && w_read) ? bus.mem_dout : 32'd0;
            end else begin
              r_done1  <= 1'b1;
              r_err1   <= ~w_accept;
              r_rdata1 <= (w_accept && w_read) ? bus.mem_dout : 32'd0;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.r0_gnt   = r_gnt0;
  assign bus.r1_gnt   = r_gnt1;
  assign bus.r0_done  = r_done0;
  assign bus.r1_done  = r_done1;
  assign bus.r0_err   = r_err0;
  assign bus.r1_err   = r_err1;
  assign bus.r0_rdata = r_rdata0;
  assign bus.r1_rdata = r_rdata1;

  assign bus.mem_en   = r_gnt0 | r_gnt1;
  assign bus.mem_we   = (r_gnt0 | r_gnt1) ? r_we : 4'd0;
  assign bus.mem_addr = r_addr;
  assign bus.mem_din  = r_din;

  assign bus.busy     = w_req0 | w_req1 | (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed bench for mem_port_arbiter (MAX_WAIT = 4) with a
//                transaction-level reference model compared every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   check_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model: owner + elapsed wait cycles ----------
  int          m_owner = -1;    // -1 none, else requester id holding the port
  int          m_waits = 0;
  bit          m_last  = 1'b1;
  logic [3:0]  m_we    = 4'd0;
  logic [31:0] m_addr  = 32'd0;
  logic [31:0] m_din   = 32'd0;
  bit          m_done [2] = '{1'b0, 1'b0};
  bit          m_err  [2] = '{1'b0, 1'b0};
  logic [31:0] m_rdata[2] = '{32'd0, 32'd0};
  bit          nd[2];
  bit          acc, e0, e1;
  int          who;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_waits = 0; m_last = 1'b1;
      m_done  = '{1'b0, 1'b0};
      m_err   = '{1'b0, 1'b0};
      m_rdata = '{32'd0, 32'd0};
    end else begin
      nd = '{1'b0, 1'b0};
      if (m_owner >= 0) begin
        acc = (m_we == 4'd0) ? bus.mem_accept_read : bus.mem_accept_write;
        if (acc) begin
          nd[m_owner]      = 1'b1;
          m_err[m_owner]   = 1'b0;
          m_rdata[m_owner] = (m_we == 4'd0) ? bus.mem_dout : 32'd0;
          m_owner = -1;
        end else begin
          m_waits++;
          if (m_waits == MAX_WAIT) begin
            nd[m_owner]      = 1'b1;
            m_err[m_owner]   = 1'b1;
            m_rdata[m_owner] = 32'd0;
            m_owner = -1;
          end
        end
      end else begin
        e0 = bus.r0_req && !m_done[0];
        e1 = bus.r1_req && !m_done[1];
        if (e0 || e1) begin
          who     = (e0 && e1) ? (m_last ? 0 : 1) : (e1 ? 1 : 0);
          m_owner = who;
          m_last  = (who == 1);
          m_waits = 0;
          m_we    = (who == 1) ? bus.r1_we    : bus.r0_we;
          m_addr  = (who == 1) ? bus.r1_addr  : bus.r0_addr;
          m_din   = (who == 1) ? bus.r1_wdata : bus.r0_wdata;
        end
      end
      m_done = nd;
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("gnt0",   bus.r0_gnt,  32'(m_owner == 0));
      chk("gnt1",   bus.r1_gnt,  32'(m_owner == 1));
      chk("mem_en", bus.mem_en,  32'(m_owner >= 0));
      if (m_owner >= 0) begin
        chk("mem_we",   bus.mem_we,   m_we);
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_din",  bus.mem_din,  m_din);
      end else begin
        chk("mem_we_idle", bus.mem_we, 32'd0);
      end
      chk("done0", bus.r0_done, 32'(m_done[0]));
      chk("done1", bus.r1_done, 32'(m_done[1]));
      if (m_done[0]) chk("err0", bus.r0_err, 32'(m_err[0]));
      if (m_done[1]) chk("err1", bus.r1_err, 32'(m_err[1]));
      chk("rdata0", bus.r0_rdata, m_rdata[0]);
      chk("rdata1", bus.r1_rdata, m_rdata[1]);
      chk("busy", bus.busy,
          32'((bus.r0_req && !m_done[0]) || (bus.r1_req && !m_done[1]) || (m_owner >= 0)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.r0_req = 1'b0; bus.r0_we = 4'd0; bus.r0_addr = 32'd0; bus.r0_wdata = 32'd0;
    bus.r1_req = 1'b0; bus.r1_we = 4'd0; bus.r1_addr = 32'd0; bus.r1_wdata = 32'd0;
    bus.mem_dout = 32'd0; bus.mem_accept_read = 1'b0; bus.mem_accept_write = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int en_cnt, dn_cnt, grants[$];

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    repeat (3) tick();
    check_en = 1'b1;
    // reset state
    @(negedge clk);
    chk("rst_mem_en", bus.mem_en, 32'd0);
    chk("rst_gnt0",   bus.r0_gnt, 32'd0);
    chk("rst_done0",  bus.r0_done, 32'd0);
    chk("rst_rdata1", bus.r1_rdata, 32'd0);
    tick();
    rst_n = 1'b1;

    // single read with minimum latency; req held through the done cycle
    bus.r0_req = 1'b1; bus.r0_we = 4'd0; bus.r0_addr = 32'h10;
    tick();
    bus.mem_accept_read = 1'b1; bus.mem_dout = 32'hDEADBEEF;
    @(negedge clk);
    chk("s1_gnt0", bus.r0_gnt, 32'd1);
    chk("s1_addr", bus.mem_addr, 32'h10);
    tick();
    bus.mem_accept_read = 1'b0; bus.mem_dout = 32'd0;
    @(negedge clk);
    chk("s1_done0", bus.r0_done, 32'd1);
    chk("s1_rdata0", bus.r0_rdata, 32'hDEADBEEF);
    chk("s1_err0", bus.r0_err, 32'd0);
    tick();
    bus.r0_req = 1'b0;
    @(negedge clk);
    chk("s1_no_regrant", bus.r0_gnt, 32'd0);
    chk("s1_done_once", bus.r0_done, 32'd0);
    tick();

    // both reading continuously after reset: strict alternation from r0
    do_reset();
    bus.r0_req = 1'b1; bus.r0_addr = 32'h100;
    bus.r1_req = 1'b1; bus.r1_addr = 32'h200;
    bus.mem_accept_read = 1'b1; bus.mem_dout = 32'hA5A50000;
    dn_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      bus.mem_dout = bus.mem_dout + 32'd1;
      @(negedge clk);
      if (bus.r0_gnt) grants.push_back(0);
      if (bus.r1_gnt) grants.push_back(1);
      dn_cnt += int'(bus.r0_done) + int'(bus.r1_done);
    end
    bus.r0_req = 1'b0; bus.r1_req = 1'b0; bus.mem_accept_read = 1'b0;
    chk("s2_n_grants", grants.size(), 32'd4);
    if (grants.size() == 4) begin
      chk("s2_g0", grants[0], 32'd0);
      chk("s2_g1", grants[1], 32'd1);
      chk("s2_g2", grants[2], 32'd0);
      chk("s2_g3", grants[3], 32'd1);
    end
    chk("s2_n_done", dn_cnt, 32'd4);
    tick(); tick();

    // slow write on r1, stray accept_read ignored, accept_write after 3 waits
    bus.r1_req = 1'b1; bus.r1_we = 4'hF; bus.r1_addr = 32'h20; bus.r1_wdata = 32'h12345678;
    en_cnt = 0; dn_cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      bus.mem_accept_read  = (i <= 2);
      bus.mem_accept_write = (i == 4);
      if (i >= 6) bus.r1_req = 1'b0;
      @(negedge clk);
      if (bus.mem_en) begin
        en_cnt++;
        chk("s3_addr", bus.mem_addr, 32'h20);
        chk("s3_din",  bus.mem_din,  32'h12345678);
      end
      if (bus.r1_done) begin
        dn_cnt++;
        chk("s3_rdata1", bus.r1_rdata, 32'd0);
        chk("s3_err1", bus.r1_err, 32'd0);
      end
    end
    chk("s3_en_cycles", en_cnt, 32'd4);
    chk("s3_n_done", dn_cnt, 32'd1);
    idle_inputs();
    tick();

    // timeout on r0 read; accept_write during a read ignored
    bus.r0_req = 1'b1; bus.r0_addr = 32'h40; bus.mem_accept_write = 1'b1;
    en_cnt = 0; dn_cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i >= 6) bus.r0_req = 1'b0;
      @(negedge clk);
      if (bus.mem_en) en_cnt++;
      if (bus.r0_done) begin
        dn_cnt++;
        chk("s4_err0", bus.r0_err, 32'd1);
        chk("s4_rdata0", bus.r0_rdata, 32'd0);
      end
    end
    chk("s4_en_cycles", en_cnt, 32'd4);
    chk("s4_n_done", dn_cnt, 32'd1);
    idle_inputs();
    tick();

    // accept in the last allowed cycle wins over timeout
    bus.r1_req = 1'b1; bus.r1_addr = 32'h44; bus.mem_dout = 32'h0BADF00D;
    dn_cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      bus.mem_accept_read = (i == 4);
      if (i >= 6) bus.r1_req = 1'b0;
      @(negedge clk);
      if (bus.r1_done) begin
        dn_cnt++;
        chk("s4b_err1", bus.r1_err, 32'd0);
        chk("s4b_rdata1", bus.r1_rdata, 32'h0BADF00D);
      end
    end
    chk("s4b_n_done", dn_cnt, 32'd1);
    idle_inputs();
    tick();

    // reset in the middle of a BUSY0 access
    bus.r0_req = 1'b1; bus.r0_addr = 32'h80;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("s5_en_async", bus.mem_en, 32'd0);
    chk("s5_gnt_async", bus.r0_gnt, 32'd0);
    bus.r1_req = 1'b1; bus.r1_addr = 32'h90;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("s5_no_done", bus.r0_done, 32'd0);
    tick();
    bus.mem_accept_read = 1'b1; bus.mem_dout = 32'h11112222;
    @(negedge clk);
    chk("s5_r0_first", bus.r0_gnt, 32'd1);
    chk("s5_r1_waits", bus.r1_gnt, 32'd0);
    tick();
    bus.mem_accept_read = 1'b0;
    tick();
    bus.r0_req = 1'b0; bus.mem_accept_read = 1'b1; bus.mem_dout = 32'h33334444;
    tick();
    bus.mem_accept_read = 1'b0;
    tick();
    bus.r1_req = 1'b0;
    tick(); tick();

    // requester drops req mid-access: access completes, no second grant
    idle_inputs();
    bus.r1_req = 1'b1; bus.r1_addr = 32'hC0;
    en_cnt = 0; dn_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) bus.r1_req = 1'b0;
      bus.mem_accept_read = (i == 2);
      bus.mem_dout = (i == 2) ? 32'h5555AAAA : 32'd0;
      @(negedge clk);
      if (bus.r1_gnt) en_cnt++;
      if (bus.r1_done) begin
        dn_cnt++;
        chk("s6_rdata1", bus.r1_rdata, 32'h5555AAAA);
      end
    end
    chk("s6_gnt_cycles", en_cnt, 32'd2);
    chk("s6_n_done", dn_cnt, 32'd1);

    idle_inputs();
    tick(); tick();
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
